// File: rtl/pmipsl_pkg.sv
// Shared encodings for the MIPS-Lite memory arbiter: FSM states and memory
// space selectors.
package pmipsl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IACC = 2'd1,
        ST_DACC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic MEM_SEL_I = 1'b0;
    localparam logic MEM_SEL_D = 1'b1;

endpackage

// File: rtl/pmipsl_sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module pmipsl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (en && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pmipsl_mem_arbiter.sv
// Single-port memory arbiter for the MIPS-Lite core: data accesses win over
// fetches, waits on mem_ready with a timeout, and drives the pipeline stall.
module pmipsl_mem_arbiter
    import pmipsl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int IDATA_W = 17,
    parameter int DDATA_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ireq,
    input  logic [ADDR_W-1:0]  iaddr,
    output logic [IDATA_W-1:0] irdata,
    output logic               iack,
    input  logic               dread,
    input  logic               dwrite,
    input  logic [ADDR_W-1:0]  daddr,
    input  logic [DDATA_W-1:0] dwdata,
    output logic [DDATA_W-1:0] drdata,
    output logic               dack,
    output logic               stall,
    output logic               err,
    output logic [15:0]        stall_cnt,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DDATA_W-1:0] mem_wdata,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               mem_sel,
    input  logic [IDATA_W-1:0] mem_rdata,
    input  logic               mem_ready
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       acc_done;

    // NOTE: stall is combinational from the requests so the core freezes in the
    // same cycle it raises a request; only the acks come from registers.
    assign stall    = (ireq & ~iack) | ((dread | dwrite) & ~dack);
    assign acc_done = mem_ready || (wait_cnt == TO_LAST);

    pmipsl_sat_counter #(.W(16)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .en    (stall),
        .count (stall_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            irdata    <= '0;
            drdata    <= '0;
            iack      <= 1'b0;
            dack      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_sel   <= MEM_SEL_I;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (dread || dwrite) begin
                        state     <= ST_DACC;
                        mem_addr  <= daddr;
                        mem_wdata <= dwdata;
                        mem_sel   <= MEM_SEL_D;
                        mem_wr    <= dwrite;
                        mem_rd    <= ~dwrite;
                        if (dread && dwrite)
                            err <= 1'b1;
                    end else if (ireq) begin
                        state    <= ST_IACC;
                        mem_addr <= iaddr;
                        mem_sel  <= MEM_SEL_I;
                        mem_rd   <= 1'b1;
                    end
                end

                ST_IACC, ST_DACC: begin
                    if (acc_done) begin
                        // A timed-out read returns zero rather than bus garbage.
                        if (state == ST_IACC) begin
                            irdata <= mem_ready ? mem_rdata : '0;
                            iack   <= 1'b1;
                        end else begin
                            if (mem_rd)
                                drdata <= mem_ready ? mem_rdata[DDATA_W-1:0] : '0;
                            dack <= 1'b1;
                        end
                        if (!mem_ready)
                            err <= 1'b1;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    iack  <= 1'b0;
                    dack  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmipsl_mem_arbiter.sv
// Directed bench for pmipsl_mem_arbiter: inputs driven and outputs sampled on
// the falling clock edge, expected values hand-computed per step.
module tb_pmipsl_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ireq;
    logic [15:0] iaddr;
    logic [16:0] irdata;
    logic        iack;
    logic        dread;
    logic        dwrite;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [15:0] drdata;
    logic        dack;
    logic        stall;
    logic        err;
    logic [15:0] stall_cnt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_sel;
    logic [16:0] mem_rdata;
    logic        mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    pmipsl_mem_arbiter #(
        .ADDR_W(16), .IDATA_W(17), .DDATA_W(16), .TIMEOUT(15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .irdata    (irdata),
        .iack      (iack),
        .dread     (dread),
        .dwrite    (dwrite),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .drdata    (drdata),
        .dack      (dack),
        .stall     (stall),
        .err       (err),
        .stall_cnt (stall_cnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_sel   (mem_sel),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".irdata"},    irdata,    0);
        check({tag, ".drdata"},    drdata,    0);
        check({tag, ".iack"},      iack,      0);
        check({tag, ".dack"},      dack,      0);
        check({tag, ".err"},       err,       0);
        check({tag, ".stall_cnt"}, stall_cnt, 0);
        check({tag, ".mem_addr"},  mem_addr,  0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
        check({tag, ".mem_rd"},    mem_rd,    0);
        check({tag, ".mem_wr"},    mem_wr,    0);
        check({tag, ".mem_sel"},   mem_sel,   0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        ireq      = 1'b0;
        iaddr     = '0;
        dread     = 1'b0;
        dwrite    = 1'b0;
        daddr     = '0;
        dwdata    = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int rd_cycles;

        // Reset state
        do_reset();
        check_zero_outputs("reset");
        check("reset.stall", stall, 0);

        // Fetch only, zero wait
        ireq = 1'b1; iaddr = 16'h0004; mem_rdata = 17'h1A2B3; mem_ready = 1'b1;
        #1 check("f0.stall_req", stall, 1);
        tick();
        check("f0.mem_rd", mem_rd, 1);
        check("f0.mem_addr", mem_addr, 16'h0004);
        check("f0.mem_sel", mem_sel, 0);
        check("f0.iack_early", iack, 0);
        tick();
        check("f0.iack", iack, 1);
        check("f0.irdata", irdata, 17'h1A2B3);
        check("f0.mem_rd_off", mem_rd, 0);
        check("f0.stall_ack", stall, 0);
        ireq = 1'b0; mem_ready = 1'b0;
        tick();
        check("f0.iack_pulse", iack, 0);

        // Simultaneous fetch and data read: data first
        do_reset();
        ireq = 1'b1; iaddr = 16'h0008; dread = 1'b1; daddr = 16'h0010;
        mem_rdata = 17'h0CAFE; mem_ready = 1'b1;
        tick();
        check("sim.d_rd", mem_rd, 1);
        check("sim.d_sel", mem_sel, 1);
        check("sim.d_addr", mem_addr, 16'h0010);
        check("sim.stall1", stall, 1);
        tick();
        check("sim.dack", dack, 1);
        check("sim.drdata", drdata, 16'hCAFE);
        check("sim.iack_not_yet", iack, 0);
        check("sim.stall2", stall, 1);
        dread = 1'b0;
        mem_rdata = 17'h12345;
        tick();
        check("sim.resp_idle_rd", mem_rd, 0);
        check("sim.dack_pulse", dack, 0);
        check("sim.stall3", stall, 1);
        tick();
        check("sim.i_rd", mem_rd, 1);
        check("sim.i_addr", mem_addr, 16'h0008);
        check("sim.i_sel", mem_sel, 0);
        check("sim.stall4", stall, 1);
        tick();
        check("sim.iack", iack, 1);
        check("sim.irdata", irdata, 17'h12345);
        check("sim.stall5", stall, 0);
        ireq = 1'b0; mem_ready = 1'b0;

        // Write with four wait states
        do_reset();
        dwrite = 1'b1; daddr = 16'h0020; dwdata = 16'hBEEF; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ws.mem_wr", mem_wr, 1);
            check("ws.mem_rd", mem_rd, 0);
            check("ws.mem_addr", mem_addr, 16'h0020);
            check("ws.mem_wdata", mem_wdata, 16'hBEEF);
            check("ws.dack_early", dack, 0);
            if (i == 4) mem_ready = 1'b1;
        end
        tick();
        check("ws.dack", dack, 1);
        check("ws.mem_wr_off", mem_wr, 0);
        check("ws.drdata_hold", drdata, 0);
        check("ws.stall_cnt", stall_cnt, 6);
        check("ws.err", err, 0);
        dwrite = 1'b0; mem_ready = 1'b0;
        tick();
        check("ws.stall_cnt_hold", stall_cnt, 6);

        // Fetch timeout
        do_reset();
        ireq = 1'b1; iaddr = 16'h0040; mem_rdata = 17'h1FFFF; mem_ready = 1'b0;
        rd_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mem_rd) rd_cycles++;
        end
        check("to.rd_cycles", rd_cycles, 15);
        tick();
        check("to.iack", iack, 1);
        check("to.irdata", irdata, 0);
        check("to.err", err, 1);
        check("to.mem_rd_off", mem_rd, 0);
        ireq = 1'b0;
        tick();
        tick();
        check("to.err_sticky", err, 1);
        check("to.iack_pulse", iack, 0);

        // dread and dwrite together: performed as a write, err set
        do_reset();
        dread = 1'b1; dwrite = 1'b1; daddr = 16'h0030; dwdata = 16'h1234;
        mem_rdata = 17'h0ABCD; mem_ready = 1'b1;
        tick();
        check("pe.mem_wr", mem_wr, 1);
        check("pe.mem_rd", mem_rd, 0);
        check("pe.mem_wdata", mem_wdata, 16'h1234);
        check("pe.err", err, 1);
        tick();
        check("pe.dack", dack, 1);
        check("pe.drdata_hold", drdata, 0);
        dread = 1'b0; dwrite = 1'b0; mem_ready = 1'b0;

        // Reset mid-access, then the held read is served again
        do_reset();
        dread = 1'b1; daddr = 16'h0050; mem_ready = 1'b0;
        tick();
        check("rm.mem_rd", mem_rd, 1);
        tick();
        reset = 1'b0;
        #1 check_zero_outputs("rm.async");
        tick();
        check("rm.no_dack", dack, 0);
        reset = 1'b1;
        mem_rdata = 17'h05555; mem_ready = 1'b1;
        tick();
        check("rm.regrant_rd", mem_rd, 1);
        check("rm.regrant_addr", mem_addr, 16'h0050);
        check("rm.dack_early", dack, 0);
        tick();
        check("rm.dack", dack, 1);
        check("rm.drdata", drdata, 16'h5555);
        dread = 1'b0; mem_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
